// File: rtl/register_file_multiport_pkg.sv
// Shared constants and the address-width helper for the multiported register file.
package register_file_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // A depth of 1 would give a zero-width address, so it is held at one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// Bus bundle for the register file: write ports, read ports and the reservation request.
interface register_file_multiport_if #(
    parameter int WIDTH       = register_file_pkg::DEFAULT_WIDTH,
    parameter int DEPTH       = register_file_pkg::DEFAULT_DEPTH,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
) ();
    import register_file_pkg::*;

    localparam int AW = addr_width(DEPTH);

    logic [WRITE_PORTS-1:0]                write_enable;
    logic [WRITE_PORTS-1:0][AW-1:0]        address_write;
    logic [WRITE_PORTS-1:0][WIDTH-1:0]     value_write;
    logic [READ_PORTS-1:0][AW-1:0]         address_read;
    logic [READ_PORTS-1:0][WIDTH-1:0]      value_read;
    logic [READ_PORTS-1:0]                 busy_read;
    logic                                  reserve_enable;
    logic [AW-1:0]                         reserve_address;

    modport master (
        output write_enable, address_write, value_write,
        output address_read, reserve_enable, reserve_address,
        input  value_read, busy_read
    );

    modport slave (
        input  write_enable, address_write, value_write,
        input  address_read, reserve_enable, reserve_address,
        output value_read, busy_read
    );

endinterface

// File: rtl/register_file_multiport_dffe.sv
// Enable-gated storage register with asynchronous active-low clear; one per register-file entry.
module register_file_multiport_dffe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file_multiport_scoreboard.sv
// Per-register busy bits: writes release a register, reservations claim it, and a claim beats a release.
module register_scoreboard #(
    parameter int DEPTH       = register_file_pkg::DEFAULT_DEPTH,
    parameter int WRITE_PORTS = 1,
    localparam int AW         = register_file_pkg::addr_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [WRITE_PORTS-1:0]         i_write_enable,
    input  logic [WRITE_PORTS-1:0][AW-1:0] i_address_write,
    input  logic                           i_reserve_enable,
    input  logic [AW-1:0]                  i_reserve_address,
    output logic [DEPTH-1:0]               o_busy
);
    import register_file_pkg::*;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;

    // Reservation is applied last so a new producer supersedes a retiring one.
    always_comb begin
        w_busy_next = r_busy;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (i_write_enable[w]) begin
                w_busy_next[i_address_write[w]] = 1'b0;
            end
        end
        if (i_reserve_enable) begin
            w_busy_next[i_reserve_address] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/register_file_multiport.sv
// Multiported architectural register file with optional zero register, write-to-read bypass
// and a busy scoreboard for operand reservation.
module register_file_multiport #(
    parameter int WIDTH       = register_file_pkg::DEFAULT_WIDTH,
    parameter int DEPTH       = register_file_pkg::DEFAULT_DEPTH,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit BYPASS      = 1'b1
) (
    input logic                      clk,
    input logic                      reset_n,
    register_file_multiport_if.slave bus
);
    import register_file_pkg::*;

    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] w_mem [DEPTH];
    logic [DEPTH-1:0] w_busy;
    logic             w_reserve_en;

    // Each entry picks up the highest-index write port addressing it.
    for (genvar r = 0; r < DEPTH; r++) begin : g_entry
        if (ZERO_REG && r == 0) begin : g_zero
            assign w_mem[r] = '0;
        end else begin : g_reg
            logic             w_we;
            logic [WIDTH-1:0] w_d;

            always_comb begin
                w_we = 1'b0;
                w_d  = '0;
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (bus.write_enable[w] && bus.address_write[w] == AW'(r)) begin
                        w_we = 1'b1;
                        w_d  = bus.value_write[w];
                    end
                end
            end

            register_file_multiport_dffe #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk     (clk),
                .reset_n (reset_n),
                .i_en    (w_we),
                .i_d     (w_d),
                .o_q     (w_mem[r])
            );
        end
    end

    assign w_reserve_en = bus.reserve_enable && !(ZERO_REG && bus.reserve_address == '0);

    register_scoreboard #(
        .DEPTH       (DEPTH),
        .WRITE_PORTS (WRITE_PORTS)
    ) u_scoreboard (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_write_enable    (bus.write_enable),
        .i_address_write   (bus.address_write),
        .i_reserve_enable  (w_reserve_en),
        .i_reserve_address (bus.reserve_address),
        .o_busy            (w_busy)
    );

    // Forwarded data is already available, so a forwarded read is never reported busy.
    always_comb begin
        bus.value_read = '0;
        bus.busy_read  = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            bus.value_read[p] = w_mem[bus.address_read[p]];
            bus.busy_read[p]  = w_busy[bus.address_read[p]];
            if (BYPASS) begin
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (bus.write_enable[w] && bus.address_write[w] == bus.address_read[p]) begin
                        bus.value_read[p] = bus.value_write[w];
                        bus.busy_read[p]  = 1'b0;
                    end
                end
            end
            if ((ZERO_REG && bus.address_read[p] == '0) || !reset_n) begin
                bus.value_read[p] = '0;
                bus.busy_read[p]  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for two register-file flavours: 2 write ports with zero register and bypass,
// and 1 write port with neither.
module tb_register_file_multiport;
    import register_file_pkg::*;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = addr_width(D);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    logic [W-1:0] memA [D];
    logic [W-1:0] memB [D];
    bit           busyA [D];
    bit           busyB [D];

    always #5 clk = ~clk;

    register_file_multiport_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(2), .WRITE_PORTS(2)) ifa ();
    register_file_multiport_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(2), .WRITE_PORTS(1)) ifb ();

    register_file_multiport #(
        .WIDTH(W), .DEPTH(D), .READ_PORTS(2), .WRITE_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    register_file_multiport #(
        .WIDTH(W), .DEPTH(D), .READ_PORTS(2), .WRITE_PORTS(1), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    // Reference model: what a read sees this cycle, derived from stored state plus pending writes.
    function automatic logic [W-1:0] expValA(input logic [AW-1:0] a);
        if (!reset_n || a == 0) return '0;
        for (int w = 1; w >= 0; w--) begin
            if (ifa.write_enable[w] && ifa.address_write[w] == a) return ifa.value_write[w];
        end
        return memA[a];
    endfunction

    function automatic bit expBusyA(input logic [AW-1:0] a);
        if (!reset_n || a == 0) return 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (ifa.write_enable[w] && ifa.address_write[w] == a) return 1'b0;
        end
        return busyA[a];
    endfunction

    function automatic logic [W-1:0] expValB(input logic [AW-1:0] a);
        return reset_n ? memB[a] : '0;
    endfunction

    function automatic bit expBusyB(input logic [AW-1:0] a);
        return reset_n ? busyB[a] : 1'b0;
    endfunction

    task automatic clearModels();
        for (int r = 0; r < D; r++) begin
            memA[r] = '0; memB[r] = '0; busyA[r] = 1'b0; busyB[r] = 1'b0;
        end
    endtask

    // Advance one edge, updating the model from the inputs that were applied.
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) begin
            clearModels();
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (ifa.write_enable[w] && ifa.address_write[w] != 0) begin
                    memA[ifa.address_write[w]]  = ifa.value_write[w];
                    busyA[ifa.address_write[w]] = 1'b0;
                end
            end
            if (ifa.reserve_enable && ifa.reserve_address != 0) busyA[ifa.reserve_address] = 1'b1;
            if (ifb.write_enable[0]) begin
                memB[ifb.address_write[0]]  = ifb.value_write[0];
                busyB[ifb.address_write[0]] = 1'b0;
            end
            if (ifb.reserve_enable) busyB[ifb.reserve_address] = 1'b1;
        end
        #1;
    endtask

    task automatic applyIdle();
        ifa.write_enable = '0; ifa.address_write = '0; ifa.value_write = '0;
        ifa.reserve_enable = 1'b0; ifa.reserve_address = '0;
        ifb.write_enable = '0; ifb.address_write = '0; ifb.value_write = '0;
        ifb.reserve_enable = 1'b0; ifb.reserve_address = '0;
    endtask

    task automatic applyStimulus();
        for (int w = 0; w < 2; w++) begin
            ifa.write_enable[w]  = 1'($urandom_range(0, 1));
            ifa.address_write[w] = AW'($urandom_range(0, 7));
            ifa.value_write[w]   = W'($urandom);
        end
        ifa.reserve_enable  = 1'($urandom_range(0, 1));
        ifa.reserve_address = AW'($urandom_range(0, 7));
        ifb.write_enable    = 1'($urandom_range(0, 1));
        ifb.address_write   = AW'($urandom_range(0, 7));
        ifb.value_write     = W'($urandom);
        ifb.reserve_enable  = 1'($urandom_range(0, 1));
        ifb.reserve_address = AW'($urandom_range(0, 7));
        for (int p = 0; p < 2; p++) begin
            ifa.address_read[p] = AW'($urandom_range(0, 7));
            ifb.address_read[p] = AW'($urandom_range(0, 7));
        end
    endtask

    task automatic test_reset();
        applyIdle();
        ifa.write_enable = 2'b11; ifa.address_write = {AW'(5), AW'(5)}; ifa.value_write = {32'h1, 32'h2};
        ifa.reserve_enable = 1'b1; ifa.reserve_address = AW'(5);
        ifa.address_read = {AW'(5), AW'(5)}; ifb.address_read = {AW'(5), AW'(5)};
        #1;
        for (int p = 0; p < 2; p++) begin
            total += 4;
            if (ifa.value_read[p] !== '0) begin bad++; $display("[TB] FAIL reset_a_val[%0d]: got %h expected 0", p, ifa.value_read[p]); end
            if (ifa.busy_read[p] !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_busy[%0d]: got %b expected 0", p, ifa.busy_read[p]); end
            if (ifb.value_read[p] !== '0) begin bad++; $display("[TB] FAIL reset_b_val[%0d]: got %h expected 0", p, ifb.value_read[p]); end
            if (ifb.busy_read[p] !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_busy[%0d]: got %b expected 0", p, ifb.busy_read[p]); end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        ifa.value_write = {32'hA5A5_0005, 32'h0};
        ifb.write_enable = 1'b1; ifb.address_write = AW'(5); ifb.value_write = 32'h5A5A_0005;
        ifb.reserve_enable = 1'b1; ifb.reserve_address = AW'(5);
        cycle();
        total += 2;
        if (ifa.value_read[0] !== 32'hA5A5_0005) begin bad++; $display("[TB] FAIL prereset_a_val: got %h expected a5a50005", ifa.value_read[0]); end
        if (ifb.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL prereset_b_busy: got %b expected 1", ifb.busy_read[0]); end
        #2;
        reset_n = 1'b0;
        clearModels();
        #1;
        for (int p = 0; p < 2; p++) begin
            total += 4;
            if (ifa.value_read[p] !== '0) begin bad++; $display("[TB] FAIL async_a_val[%0d]: got %h expected 0", p, ifa.value_read[p]); end
            if (ifa.busy_read[p] !== 1'b0) begin bad++; $display("[TB] FAIL async_a_busy[%0d]: got %b expected 0", p, ifa.busy_read[p]); end
            if (ifb.value_read[p] !== '0) begin bad++; $display("[TB] FAIL async_b_val[%0d]: got %h expected 0", p, ifb.value_read[p]); end
            if (ifb.busy_read[p] !== 1'b0) begin bad++; $display("[TB] FAIL async_b_busy[%0d]: got %b expected 0", p, ifb.busy_read[p]); end
        end
        cycle();
        applyIdle();
        reset_n = 1'b1;
    endtask

    task automatic test_write_latency();
        applyIdle();
        ifa.write_enable[0] = 1'b1; ifa.address_write[0] = AW'(7); ifa.value_write[0] = 32'hDEAD_BEEF;
        ifb.write_enable[0] = 1'b1; ifb.address_write[0] = AW'(7); ifb.value_write[0] = 32'hDEAD_BEEF;
        ifa.address_read[0] = AW'(7); ifb.address_read[0] = AW'(7);
        #3;
        total += 2;
        if (ifb.value_read[0] !== 32'h0) begin bad++; $display("[TB] FAIL nobypass_same_cycle: got %h expected 0", ifb.value_read[0]); end
        if (ifa.value_read[0] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", ifa.value_read[0]); end
        cycle();
        applyIdle();
        #1;
        total += 2;
        if (ifb.value_read[0] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL nobypass_next_cycle: got %h expected deadbeef", ifb.value_read[0]); end
        if (ifa.value_read[0] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL bypass_next_cycle: got %h expected deadbeef", ifa.value_read[0]); end
    endtask

    task automatic test_collision();
        applyIdle();
        ifa.write_enable = 2'b11; ifa.address_write = {AW'(3), AW'(3)}; ifa.value_write = {32'h22, 32'h11};
        ifa.address_read[1] = AW'(3);
        #3;
        total++;
        if (ifa.value_read[1] !== 32'h22) begin bad++; $display("[TB] FAIL collision_bypass: got %h expected 22", ifa.value_read[1]); end
        cycle();
        applyIdle();
        #1;
        total++;
        if (ifa.value_read[1] !== 32'h22) begin bad++; $display("[TB] FAIL collision_stored: got %h expected 22", ifa.value_read[1]); end
    endtask

    task automatic test_zero_reg();
        applyIdle();
        ifa.write_enable[0] = 1'b1; ifa.address_write[0] = '0; ifa.value_write[0] = 32'hFFFF_FFFF;
        ifa.reserve_enable = 1'b1; ifa.reserve_address = '0; ifa.address_read[0] = '0;
        ifb.write_enable[0] = 1'b1; ifb.address_write[0] = '0; ifb.value_write[0] = 32'h0000_1234;
        ifb.reserve_enable = 1'b1; ifb.reserve_address = '0; ifb.address_read[0] = '0;
        #3;
        total += 2;
        if (ifa.value_read[0] !== '0) begin bad++; $display("[TB] FAIL zero_val_before: got %h expected 0", ifa.value_read[0]); end
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_before: got %b expected 0", ifa.busy_read[0]); end
        cycle();
        applyIdle();
        #1;
        total += 4;
        if (ifa.value_read[0] !== '0) begin bad++; $display("[TB] FAIL zero_val_after: got %h expected 0", ifa.value_read[0]); end
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_after: got %b expected 0", ifa.busy_read[0]); end
        if (ifb.value_read[0] !== 32'h0000_1234) begin bad++; $display("[TB] FAIL x0_plain_val: got %h expected 00001234", ifb.value_read[0]); end
        if (ifb.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL x0_plain_busy: got %b expected 1", ifb.busy_read[0]); end
    endtask

    task automatic test_scoreboard();
        applyIdle();
        ifa.address_read[0] = AW'(9); ifb.address_read[0] = AW'(9);
        ifa.reserve_enable = 1'b1; ifa.reserve_address = AW'(9);
        ifb.reserve_enable = 1'b1; ifb.reserve_address = AW'(9);
        #3;
        total++;
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_reserve_before: got %b expected 0", ifa.busy_read[0]); end
        cycle();
        applyIdle();
        #1;
        total += 2;
        if (ifa.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_reserve_a: got %b expected 1", ifa.busy_read[0]); end
        if (ifb.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_reserve_b: got %b expected 1", ifb.busy_read[0]); end
        ifa.write_enable[1] = 1'b1; ifa.address_write[1] = AW'(9); ifa.value_write[1] = 32'h99;
        ifb.write_enable[0] = 1'b1; ifb.address_write[0] = AW'(9); ifb.value_write[0] = 32'h99;
        #2;
        total += 3;
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_write_bypass_busy: got %b expected 0", ifa.busy_read[0]); end
        if (ifa.value_read[0] !== 32'h99) begin bad++; $display("[TB] FAIL sb_write_bypass_val: got %h expected 99", ifa.value_read[0]); end
        if (ifb.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_write_nobypass_busy: got %b expected 1", ifb.busy_read[0]); end
        cycle();
        applyIdle();
        #1;
        total += 2;
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_release_a: got %b expected 0", ifa.busy_read[0]); end
        if (ifb.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_release_b: got %b expected 0", ifb.busy_read[0]); end
        ifa.write_enable[0] = 1'b1; ifa.address_write[0] = AW'(9); ifa.value_write[0] = 32'hAB;
        ifa.reserve_enable = 1'b1; ifa.reserve_address = AW'(9);
        ifb.write_enable[0] = 1'b1; ifb.address_write[0] = AW'(9); ifb.value_write[0] = 32'hAB;
        ifb.reserve_enable = 1'b1; ifb.reserve_address = AW'(9);
        cycle();
        applyIdle();
        ifa.reserve_enable = 1'b1; ifa.reserve_address = AW'(9);
        #1;
        total += 2;
        if (ifa.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_reserve_wins_a: got %b expected 1", ifa.busy_read[0]); end
        if (ifb.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_reserve_wins_b: got %b expected 1", ifb.busy_read[0]); end
        cycle();
        applyIdle();
        #1;
        total++;
        if (ifa.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_rereserve: got %b expected 1", ifa.busy_read[0]); end
    endtask

    task automatic test_reset_mid();
        applyIdle();
        ifa.address_read[0] = AW'(4);
        ifa.write_enable[0] = 1'b1; ifa.address_write[0] = AW'(4); ifa.value_write[0] = 32'h55;
        ifa.reserve_enable = 1'b1; ifa.reserve_address = AW'(4);
        cycle();
        applyIdle();
        #1;
        total += 2;
        if (ifa.value_read[0] !== 32'h55) begin bad++; $display("[TB] FAIL mid_setup_val: got %h expected 55", ifa.value_read[0]); end
        if (ifa.busy_read[0] !== 1'b1) begin bad++; $display("[TB] FAIL mid_setup_busy: got %b expected 1", ifa.busy_read[0]); end
        ifa.write_enable[0] = 1'b1; ifa.address_write[0] = AW'(4); ifa.value_write[0] = 32'h77;
        ifa.reserve_enable = 1'b1; ifa.reserve_address = AW'(4);
        #1;
        reset_n = 1'b0;
        clearModels();
        #1;
        total += 2;
        if (ifa.value_read[0] !== '0) begin bad++; $display("[TB] FAIL mid_reset_val: got %h expected 0", ifa.value_read[0]); end
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", ifa.busy_read[0]); end
        cycle();
        applyIdle();
        reset_n = 1'b1;
        #1;
        total += 2;
        if (ifa.value_read[0] !== '0) begin bad++; $display("[TB] FAIL mid_discard_val: got %h expected 0", ifa.value_read[0]); end
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL mid_discard_busy: got %b expected 0", ifa.busy_read[0]); end
        @(posedge clk); #1;
        ifa.write_enable[0] = 1'b1; ifa.address_write[0] = AW'(4); ifa.value_write[0] = 32'h66;
        cycle();
        applyIdle();
        #1;
        total += 2;
        if (ifa.value_read[0] !== 32'h66) begin bad++; $display("[TB] FAIL mid_after_val: got %h expected 66", ifa.value_read[0]); end
        if (ifa.busy_read[0] !== 1'b0) begin bad++; $display("[TB] FAIL mid_after_busy: got %b expected 0", ifa.busy_read[0]); end
    endtask

    task automatic test_random();
        logic [W-1:0] ev;
        bit           eb;
        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            #3;
            for (int p = 0; p < 2; p++) begin
                ev = expValA(ifa.address_read[p]);
                eb = expBusyA(ifa.address_read[p]);
                total += 2;
                if (ifa.value_read[p] !== ev) begin bad++; $display("[TB] FAIL rand_a_val[%0d] iter %0d: got %h expected %h", p, i, ifa.value_read[p], ev); end
                if (ifa.busy_read[p] !== eb) begin bad++; $display("[TB] FAIL rand_a_busy[%0d] iter %0d: got %b expected %b", p, i, ifa.busy_read[p], eb); end
                ev = expValB(ifb.address_read[p]);
                eb = expBusyB(ifb.address_read[p]);
                total += 2;
                if (ifb.value_read[p] !== ev) begin bad++; $display("[TB] FAIL rand_b_val[%0d] iter %0d: got %h expected %h", p, i, ifb.value_read[p], ev); end
                if (ifb.busy_read[p] !== eb) begin bad++; $display("[TB] FAIL rand_b_busy[%0d] iter %0d: got %b expected %b", p, i, ifb.busy_read[p], eb); end
            end
            cycle();
        end
        applyIdle();
    endtask

    initial begin
        clearModels();
        applyIdle();
        ifa.address_read = '0;
        ifb.address_read = '0;
        $display("[TB] starting register_file_multiport bench");
        test_reset();
        test_write_latency();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
